// File: rtl/data_io_pkg.sv
// Shared constants and framer state type for the data_io SPI blocks.
package data_io_pkg;

  localparam logic [7:0] CmdSetIndex   = 8'h55;
  localparam logic [7:0] CmdUploadCtrl = 8'h56;
  localparam logic [7:0] CmdUploadData = 8'h57;

  typedef enum logic [2:0] {
    StCmd,
    StIdxArg,
    StRxArg,
    StData,
    StIgnore
  } framer_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizers for the host SPI pins plus SCK rise/fall strobes in clk_sys.
module spi_edge_sync (
  input  logic clk_sys,
  input  logic reset,
  input  logic sck,
  input  logic ss_n,
  input  logic di,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_n_sync,
  output logic di_sync
);

  logic [1:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] di_q;
  logic       sck_prev_q;

  // Idle bus: chip select deasserted, clock low.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sck_q      <= 2'b00;
      ss_q       <= 2'b11;
      di_q       <= 2'b00;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[0], sck};
      ss_q       <= {ss_q[0], ss_n};
      di_q       <= {di_q[0], di};
      sck_prev_q <= sck_q[1];
    end
  end

  assign sck_rise  = sck_q[1] & ~sck_prev_q;
  assign sck_fall  = ~sck_q[1] & sck_prev_q;
  assign ss_n_sync = ss_q[1];
  assign di_sync   = di_q[1];

endmodule

// File: rtl/data_io_upload.sv
// SPI upload channel: host reads core memory byte-by-byte over MISO with a one-byte
// prefetch buffer so each byte is ready before the host clocks it out.
module data_io_upload
  import data_io_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic              SPI_DO,
  output logic              SPI_DO_OE,
  output logic              ioctl_upload,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic              ioctl_rd,
  input  logic [7:0]        ioctl_din,
  output logic              underrun
);

  localparam int unsigned LatW = $clog2(RD_LAT + 1);

  logic sck_rise, sck_fall, ss_n, di;

  spi_edge_sync u_sync (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .sck      (SPI_SCK),
    .ss_n     (SPI_SS2),
    .di       (SPI_DI),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_n_sync(ss_n),
    .di_sync  (di)
  );

  framer_state_e   state_q, state_d;
  logic [2:0]      bit_cnt_q;
  logic [6:0]      rx_q;
  logic [7:0]      rx_byte;
  logic            rise, fall, byte_done;
  logic            idx_load, ctrl_load, boundary;
  logic [7:0]      tx_q, pf_data_q;
  logic            skip_fall_q, valid_q, req_q, busy_q, drop_q, rd_done;
  logic [LatW-1:0] lat_q;

  assign rise      = sck_rise & ~ss_n;
  assign fall      = sck_fall & ~ss_n;
  assign rx_byte   = {rx_q, di};
  assign byte_done = rise && (bit_cnt_q == 3'd7);
  assign rd_done   = busy_q && (lat_q == LatW'(1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= StCmd;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ss_n) begin
      state_d = StCmd;
    end else if (byte_done) begin
      unique case (state_q)
        StCmd: begin
          if (rx_byte == CmdSetIndex)                        state_d = StIdxArg;
          else if (rx_byte == CmdUploadCtrl)                 state_d = StRxArg;
          else if (rx_byte == CmdUploadData && ioctl_upload) state_d = StData;
          else                                               state_d = StIgnore;
        end
        StIdxArg, StRxArg: state_d = StIgnore;
        StData:            state_d = StData;
        StIgnore:          state_d = StIgnore;
        default:           state_d = StCmd;
      endcase
    end
  end

  always_comb begin
    SPI_DO_OE = (state_q == StData);
    SPI_DO    = SPI_DO_OE & tx_q[7];
    ioctl_rd  = req_q & ~busy_q;
    idx_load  = byte_done && (state_q == StIdxArg);
    ctrl_load = byte_done && (state_q == StRxArg);
    // Covers both DATA entry (end of the 0x57 byte) and every later byte end.
    boundary  = byte_done && (state_d == StData);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
    end else if (ss_n) begin
      bit_cnt_q <= 3'd0;
    end else if (rise) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      rx_q      <= rx_byte[6:0];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_index  <= 8'd0;
      ioctl_upload <= 1'b0;
      ioctl_addr   <= '0;
      underrun     <= 1'b0;
      tx_q         <= 8'd0;
      pf_data_q    <= 8'd0;
      skip_fall_q  <= 1'b0;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
      lat_q        <= '0;
    end else begin
      if (ioctl_rd) begin
        busy_q <= 1'b1;
        lat_q  <= LatW'(RD_LAT);
        req_q  <= 1'b0;
      end else if (rd_done) begin
        busy_q <= 1'b0;
        drop_q <= 1'b0;
        if (!drop_q) begin
          pf_data_q <= ioctl_din;
          valid_q   <= 1'b1;
        end
      end else if (busy_q) begin
        lat_q <= lat_q - LatW'(1);
      end

      if (idx_load) ioctl_index <= rx_byte;

      if (ctrl_load) begin
        if (rx_byte != 8'd0) begin
          ioctl_upload <= 1'b1;
          ioctl_addr   <= '0;
          underrun     <= 1'b0;
          valid_q      <= 1'b0;
          req_q        <= 1'b1;
          // A read still in flight belongs to the old session; discard its data.
          drop_q       <= (busy_q & ~rd_done) | ioctl_rd;
        end else begin
          ioctl_upload <= 1'b0;
        end
      end

      if (boundary) begin
        if (valid_q) begin
          tx_q       <= pf_data_q;
          valid_q    <= 1'b0;
          ioctl_addr <= ioctl_addr + ADDR_W'(1);
          req_q      <= 1'b1;
        end else begin
          tx_q     <= 8'hFF;
          underrun <= 1'b1;
        end
        skip_fall_q <= 1'b1;
      end else if (fall) begin
        if (skip_fall_q) skip_fall_q <= 1'b0;
        else             tx_q        <= {tx_q[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_data_io_upload.sv
// Directed bench: three DUTs on one SPI bus (RD_LAT 1, RD_LAT 4, and a stalled memory).
module tb_data_io_upload;

  localparam int unsigned Half    = 4;   // SCK half period in clk_sys cycles (clk_sys/8)
  localparam int unsigned SlowLat = 96;  // longer than one byte time: memory stalls past boundary

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sck, ss_n, mosi;

  logic        do_a, oe_a, up_a, rd_a, ur_a;
  logic [7:0]  idx_a, din_a;
  logic [24:0] addr_a;
  logic        do_b, oe_b, up_b, rd_b, ur_b;
  logic [7:0]  idx_b, din_b;
  logic [24:0] addr_b;
  logic        do_s, oe_s, up_s, rd_s, ur_s;
  logic [7:0]  idx_s, din_s;
  logic [24:0] addr_s;

  data_io_upload #(.RD_LAT(1), .ADDR_W(25)) dut_a (
    .clk_sys(clk), .reset(rst), .SPI_SCK(sck), .SPI_SS2(ss_n), .SPI_DI(mosi),
    .SPI_DO(do_a), .SPI_DO_OE(oe_a), .ioctl_upload(up_a), .ioctl_index(idx_a),
    .ioctl_addr(addr_a), .ioctl_rd(rd_a), .ioctl_din(din_a), .underrun(ur_a)
  );

  data_io_upload #(.RD_LAT(4), .ADDR_W(25)) dut_b (
    .clk_sys(clk), .reset(rst), .SPI_SCK(sck), .SPI_SS2(ss_n), .SPI_DI(mosi),
    .SPI_DO(do_b), .SPI_DO_OE(oe_b), .ioctl_upload(up_b), .ioctl_index(idx_b),
    .ioctl_addr(addr_b), .ioctl_rd(rd_b), .ioctl_din(din_b), .underrun(ur_b)
  );

  data_io_upload #(.RD_LAT(SlowLat), .ADDR_W(25)) dut_s (
    .clk_sys(clk), .reset(rst), .SPI_SCK(sck), .SPI_SS2(ss_n), .SPI_DI(mosi),
    .SPI_DO(do_s), .SPI_DO_OE(oe_s), .ioctl_upload(up_s), .ioctl_index(idx_s),
    .ioctl_addr(addr_s), .ioctl_rd(rd_s), .ioctl_din(din_s), .underrun(ur_s)
  );

  // Memory: mem[i] = 0xA0 + i, data present only in the cycle RD_LAT after the strobe.
  always @(posedge clk) din_a <= rd_a ? 8'hA0 + addr_a[7:0] : 8'h5A;

  logic [7:0] pipe_b [4];
  always @(posedge clk) begin
    pipe_b[0] <= rd_b ? 8'hA0 + addr_b[7:0] : 8'h5A;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign din_b = pipe_b[3];

  logic [7:0] pipe_s [SlowLat];
  always @(posedge clk) begin
    pipe_s[0] <= rd_s ? 8'hA0 + addr_s[7:0] : 8'h5A;
    for (int i = 1; i < SlowLat; i++) pipe_s[i] <= pipe_s[i-1];
  end
  assign din_s = pipe_s[SlowLat-1];

  int rdcnt_a = 0;
  always @(posedge clk) if (rd_a) rdcnt_a <= rdcnt_a + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  rx_a, rx_b, rx_s;
  logic        oe_seen;
  logic [24:0] snap_addr_a;
  int          snap_rd_a, rd_base;

  // Mode 0 host: DI set while SCK low, MISO sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      repeat (Half) @(negedge clk);
      rx_a = {rx_a[6:0], do_a};
      rx_b = {rx_b[6:0], do_b};
      rx_s = {rx_s[6:0], do_s};
      oe_seen = oe_seen | oe_a | oe_b | oe_s;
      snap_addr_a = addr_a;
      snap_rd_a   = rdcnt_a;
      sck = 1'b1;
      repeat (Half) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    spi_bits(tx, 8);
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (Half) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame2(input logic [7:0] cmd, input logic [7:0] arg);
    ss_low();
    spi_byte(cmd);
    spi_byte(arg);
    ss_high();
  endtask

  task automatic test_reset();
    rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({do_a, oe_a, up_a, rd_a, ur_a} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 00000", {do_a, oe_a, up_a, rd_a, ur_a});
    end
    n_cmp++;
    if (idx_a !== 8'h00) begin n_err++; $display("FAIL reset_index: got %h want 00", idx_a); end
    n_cmp++;
    if (addr_a !== 25'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({oe_a, rd_a, oe_b, rd_b} !== 4'b0) begin
      n_err++; $display("FAIL post_reset_idle: got %b want 0000", {oe_a, rd_a, oe_b, rd_b});
    end
  endtask

  task automatic test_index();
    frame2(8'h55, 8'h03);
    n_cmp++;
    if ({idx_a, idx_b, idx_s} !== {3{8'h03}}) begin
      n_err++; $display("FAIL index: got %h %h %h want 03", idx_a, idx_b, idx_s);
    end
    n_cmp++;
    if ({up_a, up_b, up_s} !== 3'b000) begin
      n_err++; $display("FAIL index_upload: got %b want 000", {up_a, up_b, up_s});
    end
  endtask

  task automatic test_upload();
    logic [7:0] exp;
    rd_base = rdcnt_a;
    frame2(8'h56, 8'h01);
    n_cmp++;
    if ({up_a, up_b} !== 2'b11) begin n_err++; $display("FAIL upload_on: got %b want 11", {up_a, up_b}); end
    n_cmp++;
    if (addr_a !== 25'd0) begin n_err++; $display("FAIL upload_addr0: got %0d want 0", addr_a); end
    ss_low();
    spi_byte(8'h57);
    n_cmp++;
    if ({oe_a, oe_b} !== 2'b11) begin n_err++; $display("FAIL data_oe: got %b want 11", {oe_a, oe_b}); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'hA0 + 8'(i);
      spi_byte(8'h00);
      n_cmp++;
      if (rx_a !== exp) begin n_err++; $display("FAIL miso_lat1[%0d]: got %h want %h", i, rx_a, exp); end
      n_cmp++;
      if (rx_b !== exp) begin n_err++; $display("FAIL miso_lat4[%0d]: got %h want %h", i, rx_b, exp); end
    end
    n_cmp++;
    if (snap_addr_a !== 25'd4) begin n_err++; $display("FAIL upload_addr4: got %0d want 4", snap_addr_a); end
    n_cmp++;
    if (snap_rd_a - rd_base != 5) begin
      n_err++; $display("FAIL rd_pulses: got %0d want 5", snap_rd_a - rd_base);
    end
    n_cmp++;
    if ({ur_a, ur_b} !== 2'b00) begin n_err++; $display("FAIL no_underrun: got %b want 00", {ur_a, ur_b}); end
    ss_high();
    n_cmp++;
    if ({do_a, oe_a} !== 2'b00) begin n_err++; $display("FAIL oe_release: got %b want 00", {do_a, oe_a}); end
  endtask

  task automatic test_resume();
    frame2(8'h56, 8'h01);
    ss_low();
    spi_byte(8'h57);
    spi_byte(8'h00);
    n_cmp++;
    if (rx_a !== 8'hA0) begin n_err++; $display("FAIL resume_first: got %h want a0", rx_a); end
    spi_bits(8'h00, 3);
    ss_high();
    ss_low();
    spi_byte(8'h57);
    spi_byte(8'h00);
    n_cmp++;
    if (rx_a !== 8'hA2) begin n_err++; $display("FAIL resume_byte: got %h want a2", rx_a); end
    n_cmp++;
    if (rx_b !== 8'hA2) begin n_err++; $display("FAIL resume_byte_lat4: got %h want a2", rx_b); end
    ss_high();
  endtask

  task automatic test_stall();
    frame2(8'h56, 8'h01);
    n_cmp++;
    if (ur_s !== 1'b0) begin n_err++; $display("FAIL underrun_clear: got %b want 0", ur_s); end
    ss_low();
    spi_byte(8'h57);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (ur_s !== 1'b1) begin n_err++; $display("FAIL underrun_set: got %b want 1", ur_s); end
    n_cmp++;
    if (addr_s !== 25'd0) begin n_err++; $display("FAIL underrun_addr: got %0d want 0", addr_s); end
    spi_byte(8'h00);
    n_cmp++;
    if (rx_s !== 8'hFF) begin n_err++; $display("FAIL underrun_byte: got %h want ff", rx_s); end
    n_cmp++;
    if (rx_a !== 8'hA0) begin n_err++; $display("FAIL fast_mem_byte: got %h want a0", rx_a); end
    ss_high();
  endtask

  task automatic test_reset_mid_frame();
    frame2(8'h56, 8'h01);
    ss_low();
    spi_byte(8'h57);
    spi_bits(8'h00, 5);
    n_cmp++;
    if (oe_a !== 1'b1) begin n_err++; $display("FAIL pre_reset_oe: got %b want 1", oe_a); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({do_a, oe_a, up_a, rd_a, ur_a} !== 5'b0) begin
      n_err++; $display("FAIL midreset_ctl: got %b want 00000", {do_a, oe_a, up_a, rd_a, ur_a});
    end
    n_cmp++;
    if ({idx_a, addr_a} !== 33'd0) begin
      n_err++; $display("FAIL midreset_idx_addr: got %h %0d want 00 0", idx_a, addr_a);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ss_high();
    ss_low();
    oe_seen = 1'b0;
    spi_byte(8'h57);
    spi_byte(8'h00);
    n_cmp++;
    if (oe_seen !== 1'b0) begin n_err++; $display("FAIL oe_after_reset: got %b want 0", oe_seen); end
    n_cmp++;
    if (rx_a !== 8'h00) begin n_err++; $display("FAIL miso_after_reset: got %h want 00", rx_a); end
    ss_high();
  endtask

  initial begin
    rx_a = 8'h00; rx_b = 8'h00; rx_s = 8'h00; oe_seen = 1'b0;
    snap_addr_a = '0; snap_rd_a = 0; rd_base = 0;
    test_reset();
    test_index();
    test_upload();
    test_resume();
    test_stall();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
